queue_ptr_ctrl: RTL and testbench

Pointer controller for circular queues (ROB, issue/load-store queues). It sequences two wrap-tagged counters, head (dequeue) and tail (enqueue), behind valid/ready handshakes. It derives full, empty and occupancy, and supports a full flush and a tail rollback for branch mispredict recovery. The block holds no payload storage; the owning queue uses enq_ptr/deq_ptr as RAM write/read addresses.

---
 rtl/wrap_ptr_reg.sv | 37 +++
 rtl/queue_ptr_ctrl.sv | 89 ++++++++
 tb/tb_queue_ptr_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/wrap_ptr_reg.sv
// Wrap-tagged pointer register: {wrap, index} counter that counts modulo 2**WIDTH,
// with a synchronous load that takes priority over increment.
module wrap_ptr_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_aL,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_reg;
    logic [WIDTH-1:0] value_next;

    // Plain binary increment: the MSB acts as the wrap bit because DEPTH is a power of two.
    always_comb begin
        value_next = value_reg;
        if (load) begin
            value_next = load_val;
        end else if (inc) begin
            value_next = value_reg + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            value_reg <= '0;
        end else begin
            value_reg <= value_next;
        end
    end

    assign value = value_reg;

endmodule

// File: rtl/queue_ptr_ctrl.sv
// Head/tail pointer controller for a circular queue with flush and tail rollback.
// Holds no payload; enq_ptr/deq_ptr address the owning queue's storage.
module queue_ptr_ctrl #(
    parameter int DEPTH = 8,
    localparam int PTR_WIDTH = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_aL,
    input  logic               enq_valid,
    output logic               enq_ready,
    output logic               deq_valid,
    input  logic               deq_ready,
    input  logic               flush,
    input  logic               rollback_valid,
    input  logic [PTR_WIDTH:0] rollback_ptr,
    output logic [PTR_WIDTH:0] enq_ptr,
    output logic [PTR_WIDTH:0] deq_ptr,
    output logic [PTR_WIDTH:0] occupancy,
    output logic               full,
    output logic               empty
);

    localparam logic [PTR_WIDTH:0] DEPTH_CNT = (PTR_WIDTH + 1)'(DEPTH);

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("queue_ptr_ctrl: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [PTR_WIDTH:0] head_ptr;
    logic [PTR_WIDTH:0] tail_ptr;
    logic               enq_fire;
    logic               deq_fire;
    logic               tail_load;
    logic [PTR_WIDTH:0] tail_load_val;

    // Status comes from registers only, so ready/valid never see enq_valid/deq_ready.
    assign empty     = (head_ptr == tail_ptr);
    assign full      = (head_ptr[PTR_WIDTH-1:0] == tail_ptr[PTR_WIDTH-1:0]) &&
                       (head_ptr[PTR_WIDTH] != tail_ptr[PTR_WIDTH]);
    assign occupancy = tail_ptr - head_ptr;
    assign enq_ready = !full;
    assign deq_valid = !empty;

    assign enq_fire = enq_valid & enq_ready;
    assign deq_fire = deq_valid & deq_ready;

    // Flush beats rollback; either load suppresses the same-cycle enqueue increment.
    assign tail_load     = flush | rollback_valid;
    assign tail_load_val = flush ? '0 : rollback_ptr;

    wrap_ptr_reg #(.WIDTH(PTR_WIDTH + 1)) u_head (
        .clk      (clk),
        .rst_aL   (rst_aL),
        .load     (flush),
        .load_val ('0),
        .inc      (deq_fire),
        .value    (head_ptr)
    );

    wrap_ptr_reg #(.WIDTH(PTR_WIDTH + 1)) u_tail (
        .clk      (clk),
        .rst_aL   (rst_aL),
        .load     (tail_load),
        .load_val (tail_load_val),
        .inc      (enq_fire),
        .value    (tail_ptr)
    );

    assign enq_ptr = tail_ptr;
    assign deq_ptr = head_ptr;

`ifndef SYNTHESIS
    logic [PTR_WIDTH:0] rb_offset;
    assign rb_offset = rollback_ptr - head_ptr;

    // A rollback target must lie in [head, tail]; a same-cycle dequeue shifts the lower bound.
    a_rollback_legal: assert property (@(posedge clk) disable iff (!rst_aL)
        (rollback_valid && !flush) |-> ((rb_offset <= occupancy) && !(deq_fire && (rb_offset == '0))));

    a_occ_bound: assert property (@(posedge clk) disable iff (!rst_aL)
        occupancy <= DEPTH_CNT);

    a_full_empty_excl: assert property (@(posedge clk) disable iff (!rst_aL)
        !(full && empty));
`endif

endmodule

// File: tb/tb_queue_ptr_ctrl.sv
// Directed bench for queue_ptr_ctrl (DEPTH=4): expected pointers are queued when a step
// is driven and compared after the clock edge that applies it.
module tb_queue_ptr_ctrl;

    localparam int DEPTH = 4;
    localparam int PW    = $clog2(DEPTH);

    logic          clk;
    logic          rst_aL;
    logic          enq_valid;
    logic          enq_ready;
    logic          deq_valid;
    logic          deq_ready;
    logic          flush;
    logic          rollback_valid;
    logic [PW:0]   rollback_ptr;
    logic [PW:0]   enq_ptr;
    logic [PW:0]   deq_ptr;
    logic [PW:0]   occupancy;
    logic          full;
    logic          empty;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [PW:0] head;
        logic [PW:0] tail;
    } exp_t;

    exp_t sb[$];

    queue_ptr_ctrl #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_aL         (rst_aL),
        .enq_valid      (enq_valid),
        .enq_ready      (enq_ready),
        .deq_valid      (deq_valid),
        .deq_ready      (deq_ready),
        .flush          (flush),
        .rollback_valid (rollback_valid),
        .rollback_ptr   (rollback_ptr),
        .enq_ptr        (enq_ptr),
        .deq_ptr        (deq_ptr),
        .occupancy      (occupancy),
        .full           (full),
        .empty          (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input string what, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, what, obs, exp);
        end
    endtask

    // Derives the full status expectation from expected head/tail values.
    task automatic check_state(input string tag, input logic [PW:0] h, input logic [PW:0] t);
        logic [PW:0] occ;
        occ = t - h;
        chk(tag, "deq_ptr", int'(deq_ptr), int'(h));
        chk(tag, "enq_ptr", int'(enq_ptr), int'(t));
        chk(tag, "occupancy", int'(occupancy), int'(occ));
        chk(tag, "full", int'(full), int'(occ == DEPTH));
        chk(tag, "empty", int'(empty), int'(occ == 0));
        chk(tag, "enq_ready", int'(enq_ready), int'(occ != DEPTH));
        chk(tag, "deq_valid", int'(deq_valid), int'(occ != 0));
        $display("step %-12s head=%0d tail=%0d occ=%0d full=%0b empty=%0b",
                 tag, deq_ptr, enq_ptr, occupancy, full, empty);
    endtask

    // Drive one cycle of stimulus (called 1 time unit after a rising edge), then check.
    task automatic step(input string tag, input logic ev, input logic dr, input logic fl,
                        input logic rv, input logic [PW:0] rp,
                        input logic [PW:0] exp_h, input logic [PW:0] exp_t);
        exp_t e;
        enq_valid      = ev;
        deq_ready      = dr;
        flush          = fl;
        rollback_valid = rv;
        rollback_ptr   = rp;
        e.tag = tag; e.head = exp_h; e.tail = exp_t;
        sb.push_back(e);
        @(posedge clk);
        #1;
        enq_valid = 1'b0; deq_ready = 1'b0; flush = 1'b0; rollback_valid = 1'b0;
        e = sb.pop_front();
        check_state(e.tag, e.head, e.tail);
    endtask

    initial begin
        logic [PW:0] h;
        logic [PW:0] t;
        rst_aL = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0; flush = 1'b0;
        rollback_valid = 1'b0; rollback_ptr = '0;
        repeat (2) @(posedge clk);
        #1;
        check_state("reset", 3'd0, 3'd0);
        rst_aL = 1'b1;

        // 1: fill to full; tail ends at {wrap=1, idx=0}.
        for (int i = 1; i <= 4; i++) step($sformatf("fill%0d", i), 1, 0, 0, 0, 0, 3'd0, 3'(i));

        // 2: full blocks enq even with a same-cycle deq.
        step("full_enqdeq", 1, 1, 0, 0, 0, 3'd1, 3'd4);
        step("deq_to_2", 0, 1, 0, 0, 0, 3'd2, 3'd4);

        // 3: steady stream at occupancy 2; both pointers wrap through 7->0.
        h = 3'd2; t = 3'd4;
        for (int i = 1; i <= 12; i++) begin
            h = h + 3'd1; t = t + 3'd1;
            step($sformatf("stream%0d", i), 1, 1, 0, 0, 0, h, t);
        end

        // 4: build head=3, tail=6, then roll tail back to 4 with an enq that must drop.
        step("flush_a", 0, 0, 1, 0, 0, 3'd0, 3'd0);
        for (int i = 1; i <= 3; i++) step($sformatf("enq%0d", i), 1, 0, 0, 0, 0, 3'd0, 3'(i));
        for (int i = 1; i <= 3; i++) step($sformatf("ed%0d", i), 1, 1, 0, 0, 0, 3'(i), 3'(i + 3));
        step("rb_enq", 1, 0, 0, 1, 3'd4, 3'd3, 3'd4);

        // 5: same setup, rollback plus deq leaves the queue empty.
        step("enq5a", 1, 0, 0, 0, 0, 3'd3, 3'd5);
        step("enq5b", 1, 0, 0, 0, 0, 3'd3, 3'd6);
        step("rb_deq", 1, 1, 0, 1, 3'd4, 3'd4, 3'd4);

        // 6: flush beats rollback and handshakes at occupancy 3.
        for (int i = 1; i <= 3; i++) step($sformatf("enq6_%0d", i), 1, 0, 0, 0, 0, 3'd4, 3'(4 + i));
        enq_valid = 1'b1; deq_ready = 1'b1; flush = 1'b1; rollback_valid = 1'b1; rollback_ptr = 3'd5;
        #1;
        chk("preflush", "occupancy", int'(occupancy), 3);
        step("flush_all", 1, 1, 1, 1, 3'd5, 3'd0, 3'd0);

        step("enq7a", 1, 0, 0, 0, 0, 3'd0, 3'd1);
        enq_valid = 1'b1;
        @(posedge clk);
        #1;
        // Asynchronous reset between edges must clear state without a clock.
        rst_aL = 1'b0;
        enq_valid = 1'b0;
        #2;
        check_state("async_rst", 3'd0, 3'd0);
        @(negedge clk);
        rst_aL = 1'b1;
        @(posedge clk);
        #1;
        step("post_rst", 1, 0, 0, 0, 0, 3'd0, 3'd1);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard observed=%0d leftover expected=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
